// File: rtl/mem2serial_fmt.sv
// mem2serial_fmt: pops DW-bit words from a FIFO and streams each one MSB-first
// to a UART, as raw bytes or lowercase ASCII hex, followed by a 0-2 byte trailer.
// Ports:
//   clock, reset             - rising-edge clock, synchronous active-low reset
//   read_clock_enable        - one-cycle FIFO pop strobe
//   read_data, read_empty    - FIFO data (valid the cycle after the pop) and empty flag
//   hex_mode                 - 0 raw, 1 hex; captured when a word is latched
//   uart_ready               - UART can accept a byte
//   uart_data                - byte to transmit
//   uart_clock_enable        - byte strobe, held until uart_ready drops
//   busy                     - high whenever not idle
//   word_count               - completed words (data plus trailer), wrapping
module mem2serial_fmt #(
   parameter int unsigned DW          = 48,
   parameter int unsigned TRAILER_LEN = 1,
   parameter logic [15:0] TRAILER     = 16'h0d0a
) (
   input  logic          clock,
   input  logic          reset,
   output logic          read_clock_enable,
   input  logic [DW-1:0] read_data,
   input  logic          read_empty,
   input  logic          hex_mode,
   input  logic          uart_ready,
   output logic [7:0]    uart_data,
   output logic          uart_clock_enable,
   output logic          busy,
   output logic [15:0]   word_count
);

   localparam int unsigned NB = DW / 8;
   localparam int unsigned CW = $clog2(2 * NB + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_LOAD,
      S_SEND,
      S_WAIT_ACK,
      S_TRAIL,
      S_WAIT_TRAIL
   } state_t;

   state_t          r_state;
   logic [DW-1:0]   r_shift;
   logic            r_hex;
   logic [CW-1:0]   r_cnt;
   logic            r_tidx;
   logic            r_rce;
   logic            r_uce;
   logic [7:0]      r_data;
   logic            r_busy;
   logic [15:0]     r_wcount;

   state_t          w_state_nxt;
   logic [DW-1:0]   w_shift_nxt;
   logic            w_hex_nxt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            w_tidx_nxt;
   logic            w_rce_nxt;
   logic            w_uce_nxt;
   logic [7:0]      w_data_nxt;
   logic            w_busy_nxt;
   logic [15:0]     w_wcount_nxt;

   logic [3:0]      w_nib;
   logic [7:0]      w_hex_chr;
   logic [7:0]      w_trail_byte;

   // Top nibble to lowercase ASCII hex ('a' - 10 = 8'h57)
   assign w_nib     = r_shift[DW-1 -: 4];
   assign w_hex_chr = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib})
                                      : (8'h57 + {4'h0, w_nib});

   // Trailer index 1 selects the high byte, so a 2-byte trailer counts 1 -> 0
   assign w_trail_byte = r_tidx ? TRAILER[15:8] : TRAILER[7:0];

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt  = r_state;
      w_shift_nxt  = r_shift;
      w_hex_nxt    = r_hex;
      w_cnt_nxt    = r_cnt;
      w_tidx_nxt   = r_tidx;
      w_rce_nxt    = 1'b0;
      w_uce_nxt    = r_uce;
      w_data_nxt   = r_data;
      w_wcount_nxt = r_wcount;

      case (r_state)
         S_IDLE: begin
            if (!read_empty) begin
               w_rce_nxt   = 1'b1;
               w_state_nxt = S_POP;
            end
         end
         S_POP: begin
            w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            w_shift_nxt = read_data;
            w_hex_nxt   = hex_mode;
            w_cnt_nxt   = hex_mode ? CW'(2 * NB) : CW'(NB);
            w_state_nxt = S_SEND;
         end
         S_SEND: begin
            if (uart_ready) begin
               w_uce_nxt   = 1'b1;
               w_data_nxt  = r_hex ? w_hex_chr : r_shift[DW-1 -: 8];
               w_shift_nxt = r_hex ? (r_shift << 4) : (r_shift << 8);
               w_cnt_nxt   = r_cnt - CW'(1);
               w_state_nxt = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (!uart_ready) begin
               w_uce_nxt = 1'b0;
               if (r_cnt != '0) begin
                  w_state_nxt = S_SEND;
               end else if (TRAILER_LEN == 0) begin
                  w_wcount_nxt = r_wcount + 16'd1;
                  w_state_nxt  = S_IDLE;
               end else begin
                  w_tidx_nxt  = (TRAILER_LEN == 2);
                  w_state_nxt = S_TRAIL;
               end
            end
         end
         S_TRAIL: begin
            if (uart_ready) begin
               w_uce_nxt   = 1'b1;
               w_data_nxt  = w_trail_byte;
               w_state_nxt = S_WAIT_TRAIL;
            end
         end
         S_WAIT_TRAIL: begin
            if (!uart_ready) begin
               w_uce_nxt = 1'b0;
               if (r_tidx) begin
                  w_tidx_nxt  = 1'b0;
                  w_state_nxt = S_TRAIL;
               end else begin
                  w_wcount_nxt = r_wcount + 16'd1;
                  w_state_nxt  = S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_shift  <= '0;
         r_hex    <= 1'b0;
         r_cnt    <= '0;
         r_tidx   <= 1'b0;
         r_rce    <= 1'b0;
         r_uce    <= 1'b0;
         r_data   <= 8'h00;
         r_busy   <= 1'b0;
         r_wcount <= 16'h0000;
      end else begin
         r_state  <= w_state_nxt;
         r_shift  <= w_shift_nxt;
         r_hex    <= w_hex_nxt;
         r_cnt    <= w_cnt_nxt;
         r_tidx   <= w_tidx_nxt;
         r_rce    <= w_rce_nxt;
         r_uce    <= w_uce_nxt;
         r_data   <= w_data_nxt;
         r_busy   <= w_busy_nxt;
         r_wcount <= w_wcount_nxt;
      end
   end

   assign read_clock_enable = r_rce;
   assign uart_clock_enable = r_uce;
   assign uart_data         = r_data;
   assign busy              = r_busy;
   assign word_count        = r_wcount;

endmodule

// File: tb/tb_mem2serial_fmt.sv
// tb_mem2serial_fmt: directed bench for mem2serial_fmt with three configurations
// (48-bit/1-byte trailer, 16-bit/2-byte trailer, 16-bit/1-byte trailer). One FIFO
// and UART model serves whichever instance is selected; the others sit idle.
module tb_mem2serial_fmt;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  sel   = 2'd0;
   logic        hex   = 1'b0;
   logic [47:0] rd    = '0;
   logic        emp   = 1'b1;
   logic        rdy   = 1'b1;
   logic        stall = 1'b0;
   logic        emp_q = 1'b1;
   logic        rdy_q = 1'b1;
   int          hold  = 0;

   logic        emp_a, emp_b, emp_c, rdy_a, rdy_b, rdy_c;
   logic        rce_a, rce_b, rce_c, uce_a, uce_b, uce_c;
   logic        busy_a, busy_b, busy_c;
   logic [7:0]  ud_a, ud_b, ud_c;
   logic [15:0] wc_a, wc_b, wc_c;

   logic        s_rce, s_uce, s_busy;
   logic [7:0]  s_ud;
   logic [15:0] s_wc;

   logic        p_uce = 1'b0, p_rce = 1'b0, prev_rst = 1'b0;
   logic [7:0]  p_ud = 8'h00;
   logic [1:0]  prev_sel = 2'd0;

   logic [7:0]  rxq[$];
   logic [47:0] fifo[$];
   logic [7:0]  exp_b[$];
   logic [7:0]  snap;

   int n_checks = 0;
   int n_fail   = 0;
   int n_stb    = 0;
   int n_pop    = 0;

   always #5 clock = ~clock;

   assign emp_a = (sel == 2'd0) ? emp : 1'b1;
   assign emp_b = (sel == 2'd1) ? emp : 1'b1;
   assign emp_c = (sel == 2'd2) ? emp : 1'b1;
   assign rdy_a = (sel == 2'd0) ? rdy : 1'b1;
   assign rdy_b = (sel == 2'd1) ? rdy : 1'b1;
   assign rdy_c = (sel == 2'd2) ? rdy : 1'b1;

   mem2serial_fmt #(.DW(48), .TRAILER_LEN(1), .TRAILER(16'h0d0a)) dut_a (
      .clock(clock), .reset(reset), .read_clock_enable(rce_a), .read_data(rd),
      .read_empty(emp_a), .hex_mode(hex), .uart_ready(rdy_a), .uart_data(ud_a),
      .uart_clock_enable(uce_a), .busy(busy_a), .word_count(wc_a));

   mem2serial_fmt #(.DW(16), .TRAILER_LEN(2), .TRAILER(16'h0d0a)) dut_b (
      .clock(clock), .reset(reset), .read_clock_enable(rce_b), .read_data(rd[15:0]),
      .read_empty(emp_b), .hex_mode(hex), .uart_ready(rdy_b), .uart_data(ud_b),
      .uart_clock_enable(uce_b), .busy(busy_b), .word_count(wc_b));

   mem2serial_fmt #(.DW(16), .TRAILER_LEN(1), .TRAILER(16'h0d0a)) dut_c (
      .clock(clock), .reset(reset), .read_clock_enable(rce_c), .read_data(rd[15:0]),
      .read_empty(emp_c), .hex_mode(hex), .uart_ready(rdy_c), .uart_data(ud_c),
      .uart_clock_enable(uce_c), .busy(busy_c), .word_count(wc_c));

   // Route the selected instance to the shared models
   always_comb begin
      s_rce = rce_a; s_uce = uce_a; s_busy = busy_a; s_ud = ud_a; s_wc = wc_a;
      case (sel)
         2'd1: begin s_rce = rce_b; s_uce = uce_b; s_busy = busy_b; s_ud = ud_b; s_wc = wc_b; end
         2'd2: begin s_rce = rce_c; s_uce = uce_c; s_busy = busy_c; s_ud = ud_c; s_wc = wc_c; end
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [47:0] w);
      fifo.push_back(w);
      emp = 1'b0;
   endtask

   task automatic clear_rx();
      rxq.delete();
      n_stb = 0;
      n_pop = 0;
   endtask

   task automatic wait_wc(input logic [15:0] target, input int budget, input string tag);
      for (int i = 0; i < budget; i++) begin
         if (s_wc === target) break;
         @(negedge clock);
      end
      chk(tag, 48'(s_wc), 48'(target));
   endtask

   task automatic chk_bytes(input string tag);
      chk({tag, "_len"}, 48'(rxq.size()), 48'(exp_b.size()));
      for (int i = 0; i < exp_b.size(); i++)
         chk($sformatf("%s_b%0d", tag, i),
             (i < rxq.size()) ? 48'(rxq[i]) : 48'hx, 48'(exp_b[i]));
   endtask

   // Values the DUT sampled at the active edge
   initial forever begin
      @(posedge clock);
      emp_q = emp;
      rdy_q = rdy;
   end

   // FIFO and UART models plus protocol rule checks
   initial forever begin
      @(negedge clock);
      if (reset === 1'b1 && prev_rst === 1'b1 && sel == prev_sel) begin
         if (s_uce && !p_uce) begin
            n_stb++;
            chk("uce_rise_ready", 48'(rdy_q), 48'd1);
         end else begin
            chk("ud_hold", 48'(s_ud), 48'(p_ud));
         end
         if (s_rce) begin
            chk("pop_nonempty", 48'(emp_q), 48'd0);
            chk("pop_width", 48'(p_rce), 48'd0);
         end
      end
      if (s_rce === 1'b1) begin
         n_pop++;
         if (fifo.size() > 0) rd = fifo.pop_front();
      end
      emp = (fifo.size() == 0);
      if (s_uce === 1'b1 && rdy) begin
         rxq.push_back(s_ud);
         rdy  = 1'b0;
         hold = 3;
      end else if (hold > 0) begin
         hold--;
         if (hold == 0) rdy = !stall;
      end else begin
         rdy = !stall;
      end
      p_uce    = s_uce;
      p_ud     = s_ud;
      p_rce    = s_rce;
      prev_rst = reset;
      prev_sel = sel;
   end

   initial begin
      // Reset held with a word waiting in the FIFO
      push(48'h0123456789ab);
      repeat (3) @(negedge clock);
      chk("t1_rce", 48'(s_rce), 48'd0);
      chk("t1_uce", 48'(s_uce), 48'd0);
      chk("t1_ud", 48'(s_ud), 48'd0);
      chk("t1_busy", 48'(s_busy), 48'd0);
      chk("t1_wc", 48'(s_wc), 48'd0);
      clear_rx();
      reset = 1'b1;
      @(negedge clock);
      chk("t1_pop_first", 48'(s_rce), 48'd1);

      // Raw 48-bit word, 1-byte trailer
      wait_wc(16'd1, 400, "t2_wc");
      exp_b = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hab, 8'h0a};
      chk_bytes("t2");
      chk("t2_strobes", 48'(n_stb), 48'd7);
      chk("t2_pops", 48'(n_pop), 48'd1);
      repeat (6) @(negedge clock);

      // Hex 16-bit word, 2-byte trailer, hex_mode dropped mid-word
      sel = 2'd1;
      clear_rx();
      hex = 1'b1;
      push(48'h00000000beef);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clock);
         chk($sformatf("t3_lat_c%0d", i), 48'(s_uce), 48'd0);
      end
      @(negedge clock);
      chk("t3_lat_c4", 48'(s_uce), 48'd1);
      chk("t3_first_ud", 48'(s_ud), 48'h62);
      for (int i = 0; i < 100 && rxq.size() < 2; i++) @(negedge clock);
      hex = 1'b0;
      wait_wc(16'd1, 400, "t3_wc");
      exp_b = '{8'h62, 8'h65, 8'h65, 8'h66, 8'h0d, 8'h0a};
      chk_bytes("t3");
      chk("t3_strobes", 48'(n_stb), 48'd6);
      repeat (6) @(negedge clock);

      // Three queued raw 16-bit words back to back
      sel = 2'd2;
      clear_rx();
      repeat (2) @(negedge clock);
      push(48'h1234);
      push(48'h5678);
      push(48'h9abc);
      wait_wc(16'd3, 600, "t4_wc");
      exp_b = '{8'h12, 8'h34, 8'h0a, 8'h56, 8'h78, 8'h0a, 8'h9a, 8'hbc, 8'h0a};
      chk_bytes("t4");
      chk("t4_pops", 48'(n_pop), 48'd3);
      repeat (6) @(negedge clock);

      // Reset after the second byte of a 6-byte word
      sel = 2'd0;
      repeat (2) @(negedge clock);
      clear_rx();
      push(48'ha1a2a3a4a5a6);
      for (int i = 0; i < 200 && rxq.size() < 2; i++) @(negedge clock);
      chk("t5_two_bytes", 48'(rxq.size() >= 2), 48'd1);
      reset = 1'b0;
      @(negedge clock);
      chk("t5_uce", 48'(s_uce), 48'd0);
      chk("t5_busy", 48'(s_busy), 48'd0);
      chk("t5_wc", 48'(s_wc), 48'd0);
      @(negedge clock);
      clear_rx();
      reset = 1'b1;
      push(48'hb1b2b3b4b5b6);
      wait_wc(16'd1, 400, "t5_wc_after");
      exp_b = '{8'hb1, 8'hb2, 8'hb3, 8'hb4, 8'hb5, 8'hb6, 8'h0a};
      chk_bytes("t5");
      chk("t5_pops", 48'(n_pop), 48'd1);
      repeat (6) @(negedge clock);

      // Stalled UART, then word_count wrap from a preloaded 16'hffff
      force dut_a.r_wcount = 16'hffff;
      @(negedge clock);
      release dut_a.r_wcount;
      @(negedge clock);
      chk("t6_wc_pre", 48'(s_wc), 48'hffff);
      stall = 1'b1;
      repeat (6) @(negedge clock);
      clear_rx();
      push(48'hc0c1c2c3c4c5);
      repeat (4) @(negedge clock);
      snap = s_ud;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         chk("t6_stall_uce", 48'(s_uce), 48'd0);
         chk("t6_stall_busy", 48'(s_busy), 48'd1);
         chk("t6_stall_ud", 48'(s_ud), 48'(snap));
      end
      @(posedge clock);
      #1 stall = 1'b0;
      @(negedge clock);
      chk("t6_no_early", 48'(s_uce), 48'd0);
      @(negedge clock);
      chk("t6_strobe", 48'(s_uce), 48'd1);
      chk("t6_first_ud", 48'(s_ud), 48'hc0);
      wait_wc(16'h0000, 400, "t6_wc_wrap");
      exp_b = '{8'hc0, 8'hc1, 8'hc2, 8'hc3, 8'hc4, 8'hc5, 8'h0a};
      chk_bytes("t6");
      repeat (4) @(negedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
